// File: rtl/ama_riscv_lsu.sv
// Load/store unit sitting behind the EX-stage ALU: one data-memory transaction
// per accepted op, aligned/extended load writeback, fault pulse on bad ops or timeout.
module ama_riscv_lsu #(
  parameter int RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        dmem_req_valid,
  input  logic        dmem_req_ready,
  output logic [31:0] dmem_addr,
  output logic        dmem_we,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rsp_valid,
  input  logic [31:0] dmem_rsp_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  // Counter only has to reach RSP_TIMEOUT-1.
  localparam int CNT_W = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;
  logic             we_q, we_d;
  logic [3:0]       be_q, be_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [4:0]       rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             fault_q, fault_d;
  logic [1:0]       cause_q, cause_d;

  logic             acc_half, acc_word, acc_illegal, acc_misalign;
  logic [3:0]       acc_be;
  logic [31:0]      acc_wdata;

  function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                           input logic [31:0] rdata,
                                           input logic [1:0]  off);
    logic [31:0]        sh;
    logic signed [7:0]  sb;
    logic signed [15:0] shw;
    sh  = rdata >> {off, 3'b000};
    sb  = sh[7:0];
    shw = sh[15:0];
    case (f3)
      3'b000:  return 32'(sb);
      3'b001:  return 32'(shw);
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  assign acc_half = (req_funct3[1:0] == 2'b01);
  assign acc_word = (req_funct3[1:0] == 2'b10);
  assign acc_illegal = req_store ? (req_funct3 >= 3'd3)
                                 : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
  assign acc_misalign = (acc_half && req_addr[0]) || (acc_word && (req_addr[1:0] != 2'b00));

  always_comb begin
    acc_be    = 4'b1111;
    acc_wdata = 32'h0;
    if (req_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          acc_be    = 4'b0001 << req_addr[1:0];
          acc_wdata = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          acc_be    = 4'b0011 << req_addr[1:0];
          acc_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          acc_be    = 4'b1111;
          acc_wdata = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    off_d      = off_q;
    f3_d       = f3_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    fault_d    = 1'b0;
    cause_d    = cause_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (acc_illegal) begin
            fault_d = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (acc_misalign) begin
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = S_REQ;
            addr_d  = {req_addr[31:2], 2'b00};
            off_d   = req_addr[1:0];
            f3_d    = req_funct3;
            we_d    = req_store;
            be_d    = acc_be;
            wdata_d = acc_wdata;
            rd_d    = req_rd;
          end
        end
      end
      S_REQ: begin
        if (dmem_req_ready) begin
          if (we_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        if (dmem_rsp_valid) begin
          state_d    = S_IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = load_ext(f3_q, dmem_rsp_rdata, off_q);
        end else if ((RSP_TIMEOUT != 0) && (cnt_q == CNT_W'(RSP_TIMEOUT - 1))) begin
          state_d = S_IDLE;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Everything is reset so that a mid-transaction reset leaves clean, all-zero outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      fault_q    <= 1'b0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
    end
  end

  assign req_ready      = (state_q == S_IDLE);
  assign busy           = !req_ready;
  assign dmem_req_valid = (state_q == S_REQ);
  assign dmem_addr      = addr_q;
  assign dmem_we        = we_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_data        = wb_data_q;
  assign fault          = fault_q;
  assign fault_cause    = cause_q;

endmodule

// File: doc/ama_riscv_lsu.md
Name: ama_riscv_lsu

Overview:
- Load/store unit directly downstream of the ALU in the EX stage.
- Consumes the ALU sum (rs1 + imm) as the effective address, together with rs2 store data and funct3.
- Issues one data-memory transaction over a valid/ready request channel and a valid-only response channel.
- Returns aligned, sign- or zero-extended load data to writeback; raises a fault pulse on misaligned access, illegal funct3 or response timeout.

Parameters:
- RSP_TIMEOUT, 255: max cycles spent in WAIT before a timeout fault; 0 disables the timeout.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  EX presents a memory op
- req_ready  out  1  LSU can accept an op
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  32  effective address from ALU out_s
- req_wdata  in  32  rs2 value
- req_rd  in  5  load destination register
- dmem_req_valid  out  1  request to data memory
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  32  word-aligned address, bits[1:0] = 0
- dmem_we  out  1  write enable
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-positioned write data
- dmem_rsp_valid  in  1  read data valid
- dmem_rsp_rdata  in  32  read data word
- wb_valid  out  1  one-cycle pulse, load result valid
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- busy  out  1  op in flight; used as pipeline stall
- fault  out  1  one-cycle fault pulse
- fault_cause  out  2  01 misaligned, 10 illegal funct3, 11 timeout; held until the next fault

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, except req_ready=1; timeout counter 0. Reset mid-transaction drops the op with no wb_valid and no fault.
- Handshake: req_ready = (state==IDLE); an op is taken when req_valid & req_ready. busy = !req_ready.
- Input registration: on accept, register addr, funct3, store, rd and computed be/wdata. Upstream may change inputs from the next cycle.
- Checks at accept:
  - illegal: load funct3 in {3,6,7}; store funct3 >= 3.
  - misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Illegal has priority over misaligned.
  - On failure: next cycle fault=1 with the cause; no dmem request; state stays IDLE.
- FSM states IDLE -> REQ -> (WAIT | IDLE):
  - IDLE: accept a valid op -> REQ (or a fault pulse, as above).
  - REQ: dmem_req_valid=1; all dmem_* outputs stay stable until dmem_req_ready. On ready: store -> IDLE (store complete, no wb); load -> WAIT, counter cleared.
  - WAIT: dmem_req_valid=0. dmem_rsp_valid -> capture the result, go IDLE, wb_valid=1 on the next cycle. Otherwise the counter increments; counter==RSP_TIMEOUT-1 with no response -> fault cause 11, IDLE, no wb_valid.
- dmem_rsp_valid outside WAIT is ignored, including in the same cycle the request is accepted.
- Store lanes (o = addr[1:0]):
  - SB: be = 0001<<o, wdata = {4{rs2[7:0]}}.
  - SH: be = 0011<<o, wdata = {2{rs2[15:0]}}.
  - SW: be = 1111, wdata = rs2.
- Loads: dmem_we=0, be=1111. Extraction = rdata >> (8*o), then:
  - LB: sign-extend bit 7.
  - LBU: zero-extend byte.
  - LH: sign-extend bit 15.
  - LHU: zero-extend halfword.
  - LW: unchanged.
- Latency:
  - Store, ready held high: accept cycle N, dmem_req_valid high in N+1, IDLE and req_ready=1 at N+2.
  - Load, response in the cycle after request accept: wb_valid at N+3.
- wb_rd/wb_data hold their value after the wb_valid pulse.
- Back-to-back: a new op can be accepted in the same cycle as the wb_valid pulse.

Test Plan:
- SB addr=0x1003 wdata=0x000000A5 -> dmem_addr=0x1000, be=1000, wdata=0xA5A5A5A5, we=1; no wb_valid; req_ready back at N+2.
- LB addr=0x2001, rdata=0x12348000 -> wb_data=0xFFFFFF80 (byte 0x80 sign-extended), wb_rd as issued; LBU on the same data -> 0x00000080.
- LH addr=0x2002, rdata=0x8001_0000 -> wb_data=0xFFFF8001; LHU -> 0x00008001.
- LW addr=0x3002 -> no dmem_req_valid, fault=1 one cycle, cause=01. Load funct3=3 at addr=0x3001 -> cause=10 (illegal beats misaligned).
- dmem_req_ready held low 5 cycles during SW 0xDEADBEEF -> dmem_* stable all 5 cycles, one transfer. Then LW with no response, RSP_TIMEOUT=4 -> fault cause=11 after 4 WAIT cycles, no wb_valid, req_ready=1.
- rst_n pulled low while in WAIT -> outputs cleared immediately (async); a late dmem_rsp_valid after reset release -> ignored, no wb_valid.
